// File: rtl/keep_encoder.sv
// -----------------------------------------------------------------------------
// keep_encoder
//   Debounces three active-low push-buttons and turns each stable press into
//   the 2-bit select code consumed by the LED/value decoder. The last legal
//   code is held through button release and through illegal patterns.
//
// Ports
//   clk         : single clock, all state changes on the rising edge
//   rst         : synchronous active-high reset
//   btn_n[2:0]  : raw active-low buttons, asynchronous to clk (bit i -> LEDi)
//   a[1:0]      : held select code (registered)
//   a_stb       : one-cycle pulse on every legal-pattern commit (registered)
//   invalid     : level, set by an illegal commit, cleared by a legal commit
//                 or by a release commit
//   dbg_state_o : current FSM state (0 = WAIT, 1 = HOLD) for observation
//
// Handshake: there is no back-pressure. a_stb is a pure event strobe; a
// consumer that needs the value samples a in the same cycle a_stb is high.
// -----------------------------------------------------------------------------
module keep_encoder #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned CNT_W           = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] btn_n,
  output logic [1:0] a,
  output logic       a_stb,
  output logic       invalid,
  output logic       dbg_state_o
);

  typedef enum logic {
    ST_WAIT = 1'b0,
    ST_HOLD = 1'b1
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Two-flop synchronizer; only s2 feeds the debouncer.
  logic [2:0]       s1_q, s2_q;
  logic [2:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic [1:0]       a_q, a_d;
  logic             a_stb_q, a_stb_d;
  logic             invalid_q, invalid_d;

  logic             commit;
  logic             pat_legal;
  logic             pat_release;
  logic [1:0]       pat_code;

  // Pattern decode of the candidate: a single low line (or 100) selects.
  always_comb begin
    pat_legal   = 1'b0;
    pat_release = 1'b0;
    pat_code    = 2'd0;
    case (cand_q)
      3'b110:  begin pat_legal = 1'b1; pat_code = 2'd0; end
      3'b101:  begin pat_legal = 1'b1; pat_code = 2'd1; end
      3'b011:  begin pat_legal = 1'b1; pat_code = 2'd2; end
      3'b100:  begin pat_legal = 1'b1; pat_code = 2'd3; end
      3'b111:  pat_release = 1'b1;
      default: ;
    endcase
  end

  // Debounce FSM. A change of s2 always wins over a would-be commit.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    commit  = 1'b0;
    case (state_q)
      ST_WAIT: begin
        if (s2_q != cand_q) begin
          cand_d = s2_q;
          cnt_d  = '0;
        end else if (cnt_q == CNT_LAST) begin
          commit  = 1'b1;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (s2_q != cand_q) begin
          cand_d  = s2_q;
          cnt_d   = '0;
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_WAIT;
    endcase
  end

  // Output next-state: strobe only on a legal commit, even if the code repeats.
  always_comb begin
    a_d       = a_q;
    a_stb_d   = 1'b0;
    invalid_d = invalid_q;
    if (commit) begin
      if (pat_legal) begin
        a_d       = pat_code;
        a_stb_d   = 1'b1;
        invalid_d = 1'b0;
      end else if (pat_release) begin
        invalid_d = 1'b0;
      end else begin
        invalid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q      <= 3'b111;
      s2_q      <= 3'b111;
      cand_q    <= 3'b111;
      cnt_q     <= '0;
      state_q   <= ST_WAIT;
      a_q       <= 2'd0;
      a_stb_q   <= 1'b0;
      invalid_q <= 1'b0;
    end else begin
      s1_q      <= btn_n;
      s2_q      <= s1_q;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      state_q   <= state_d;
      a_q       <= a_d;
      a_stb_q   <= a_stb_d;
      invalid_q <= invalid_d;
    end
  end

  assign a           = a_q;
  assign a_stb       = a_stb_q;
  assign invalid     = invalid_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_keep_encoder.sv
// -----------------------------------------------------------------------------
// tb_keep_encoder
//   Directed bench for keep_encoder with DEBOUNCE_CYCLES = 4. A pattern driven
//   before edge k commits on edge k+6, i.e. on the 7th edge after it is driven.
// -----------------------------------------------------------------------------
module tb_keep_encoder;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] btn_n;
  logic [1:0] a;
  logic       a_stb;
  logic       invalid;
  logic       dbg_state_o;

  int checks = 0;
  int errors = 0;
  int stb_seen = 0;

  keep_encoder #(.DEBOUNCE_CYCLES(4), .CNT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_n       (btn_n),
    .a           (a),
    .a_stb       (a_stb),
    .invalid     (invalid),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  // Advance n rising edges, sampling 1 time unit after each edge and counting
  // every strobe observed in the window.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (a_stb === 1'b1) stb_seen++;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input int ea, input int estb,
                         input int einv, input int epulses);
    chk({tag, ".a"},       int'(a),       ea);
    chk({tag, ".a_stb"},   int'(a_stb),   estb);
    chk({tag, ".invalid"}, int'(invalid), einv);
    chk({tag, ".pulses"},  stb_seen,      epulses);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [2:0] btn;
    int         n;
    int         ea;
    int         estb;
    int         einv;
    int         epulses;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs[NVEC];

  initial begin
    // btn,   edges, a, stb, inv, pulses in window
    vecs[0]  = '{3'b111,  9, 0, 0, 0, 0};  // release after reset: no change
    vecs[1]  = '{3'b101,  6, 0, 0, 0, 0};  // one edge short of commit
    vecs[2]  = '{3'b101,  1, 1, 1, 0, 1};  // commit edge
    vecs[3]  = '{3'b101,  1, 1, 0, 0, 0};  // strobe is one cycle
    vecs[4]  = '{3'b101, 20, 1, 0, 0, 0};  // long hold: no more strobes
    vecs[5]  = '{3'b100,  7, 3, 1, 0, 1};  // code 3
    vecs[6]  = '{3'b111, 10, 3, 0, 0, 0};  // release keeps a
    vecs[7]  = '{3'b000,  7, 3, 0, 1, 0};  // illegal
    vecs[8]  = '{3'b110,  6, 3, 0, 1, 0};  // invalid held until commit
    vecs[9]  = '{3'b110,  1, 0, 1, 0, 1};  // legal commit clears invalid
    vecs[10] = '{3'b111,  9, 0, 0, 0, 0};
    vecs[11] = '{3'b110,  7, 0, 1, 0, 1};  // re-press same code strobes again
    vecs[12] = '{3'b111,  9, 0, 0, 0, 0};
    vecs[13] = '{3'b010,  7, 0, 0, 1, 0};  // illegal
    vecs[14] = '{3'b111,  6, 0, 0, 1, 0};
    vecs[15] = '{3'b111,  1, 0, 0, 0, 0};  // release commit clears invalid
    vecs[16] = '{3'b011,  7, 2, 1, 0, 1};  // code 2
    vecs[17] = '{3'b001,  7, 2, 0, 1, 0};  // illegal keeps a

    // ---- reset ----
    rst   = 1'b1;
    btn_n = 3'b111;
    tick(3);
    stb_seen = 0;
    chk_out("reset", 0, 0, 0, 0);
    chk("reset.state", int'(dbg_state_o), 0);
    rst = 1'b0;

    // ---- table ----
    for (int i = 0; i < NVEC; i++) begin
      btn_n    = vecs[i].btn;
      stb_seen = 0;
      tick(vecs[i].n);
      chk_out($sformatf("vec%0d", i), vecs[i].ea, vecs[i].estb,
              vecs[i].einv, vecs[i].epulses);
    end
    chk("hold.state", int'(dbg_state_o), 1);

    // ---- reset from HOLD with a=2, invalid=1 ----
    rst      = 1'b1;
    stb_seen = 0;
    tick(1);
    chk_out("rst_hold", 0, 0, 0, 0);
    chk("rst_hold.state", int'(dbg_state_o), 0);
    rst   = 1'b0;
    btn_n = 3'b111;
    tick(9);

    // ---- bounce: 011, 111 for two cycles mid-count, then 011 held ----
    stb_seen = 0;
    btn_n = 3'b011;
    tick(3);
    btn_n = 3'b111;
    tick(2);
    btn_n = 3'b011;
    tick(6);
    chk_out("bounce_pre", 0, 0, 0, 0);
    tick(1);
    chk_out("bounce_commit", 2, 1, 0, 1);
    tick(1);
    chk_out("bounce_after", 2, 0, 0, 1);

    // ---- reset one cycle before the commit edge of 101 ----
    btn_n = 3'b111;
    tick(9);
    stb_seen = 0;
    btn_n = 3'b101;
    tick(5);
    rst = 1'b1;
    tick(1);
    chk_out("midrst", 0, 0, 0, 0);
    rst = 1'b0;
    tick(6);
    chk_out("midrst_pre", 0, 0, 0, 0);
    tick(1);
    chk_out("midrst_commit", 1, 1, 0, 1);

    // ---- final report ----
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
